mmio_uart: RTL

- Memory-mapped UART peripheral that sits downstream of the core's data read/write port and upstream of the uart AXI-stream interfaces.
- Decodes a small register window. Core stores to TXDATA are buffered in a TX FIFO and drained to the uart transmitter. Received bytes are buffered in an RX FIFO and popped by core loads.
- Top level steers core read data from this block instead of ram when o_read_hit is high.

---
 rtl/mmio_uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 41 ++++
 rtl/mmio_uart.sv | 106 ++++++++++
 3 files changed

// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: register map, STATUS bit positions and STATUS layout for mmio_uart
package mmio_uart_pkg;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_VALID     = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_RX_FRAME_ERR = 4;
  localparam int ST_TX_DROP      = 5;
  typedef struct packed {
    logic [25:0] rsvd;
    logic        tx_drop;
    logic        rx_frame_err;
    logic        rx_overrun;
    logic        rx_valid;
    logic        tx_empty;
    logic        tx_full;
  } status_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO with wrap-bit pointers; push when full and pop when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = clk_en_i && push_i && !full_o;
  assign do_pop  = clk_en_i && pop_i && !empty_o;
  assign wr_d    = wr_q + {{AW{1'b0}}, do_push};
  assign rd_d    = rd_q + {{AW{1'b0}}, do_pop};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/mmio_uart.sv
// mmio_uart: core load/store register window feeding a UART through TX/RX FIFOs
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        i_read_req,
  input  logic [31:0] i_read_addr,
  output logic [31:0] o_read_data,
  output logic        o_read_hit,
  input  logic        i_write_enable,
  input  logic [3:0]  i_byte_enable,
  input  logic [31:0] i_write_addr,
  input  logic [31:0] i_write_data,
  output logic [7:0]  o_tx_tdata,
  output logic        o_tx_tvalid,
  input  logic        i_tx_tready,
  input  logic [7:0]  i_rx_tdata,
  input  logic        i_rx_tvalid,
  output logic        o_rx_tready,
  input  logic        i_rx_overrun,
  input  logic        i_rx_frame_err
);
  localparam int TXW = $clog2(TX_DEPTH) + 1;
  localparam int RXW = $clog2(RX_DEPTH) + 1;
  logic rd_hit, wr_hit, tx_push, rx_pop, st_rd;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [TXW-1:0] tx_count;
  logic [RXW-1:0] rx_count;
  logic [7:0] rx_head;
  status_t status;
  logic [31:0] rdata_d, rdata_q;
  logic hit_q, ovr_q, ovr_d, fe_q, fe_d, drop_q, drop_d;
  logic unused_ok;
  assign rd_hit  = i_read_req && (i_read_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_hit  = i_write_enable && (i_write_addr[31:4] == BASE_ADDR[31:4]);
  assign tx_push = wr_hit && (i_write_addr[3:2] == REG_TXDATA) && i_byte_enable[0];
  assign rx_pop  = rd_hit && (i_read_addr[3:2] == REG_RXDATA);
  assign st_rd   = rd_hit && (i_read_addr[3:2] == REG_STATUS);
  always_comb begin
    status              = '0;
    status.tx_full      = tx_full;
    status.tx_empty     = tx_empty;
    status.rx_valid     = rx_count != '0;
    status.rx_overrun   = ovr_q;
    status.rx_frame_err = fe_q;
    status.tx_drop      = drop_q;
  end
  assign rdata_d = !rd_hit ? '0
                 : rx_pop ? {24'd0, rx_empty ? 8'd0 : rx_head}
                 : st_rd  ? 32'(status)
                 : '0;
  // a new event in the same cycle as a STATUS read re-sets its bit
  assign ovr_d  = i_rx_overrun || (ovr_q && !st_rd);
  assign fe_d   = i_rx_frame_err || (fe_q && !st_rd);
  assign drop_d = (tx_push && tx_full) || (drop_q && !st_rd);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= 1'b0;
      rdata_q <= '0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else if (clk_en) begin
      hit_q   <= rd_hit;
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
      drop_q  <= drop_d;
    end
  end
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .clk_en_i (clk_en),
    .push_i   (tx_push),
    .data_i   (i_write_data[7:0]),
    .pop_i    (i_tx_tready),
    .full_o   (tx_full),
    .empty_o  (tx_empty),
    .count_o  (tx_count),
    .head_o   (o_tx_tdata)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .clk_en_i (clk_en),
    .push_i   (i_rx_tvalid),
    .data_i   (i_rx_tdata),
    .pop_i    (rx_pop),
    .full_o   (rx_full),
    .empty_o  (rx_empty),
    .count_o  (rx_count),
    .head_o   (rx_head)
  );
  assign o_tx_tvalid = !tx_empty;
  assign o_rx_tready = !rx_full;
  assign o_read_hit  = hit_q;
  assign o_read_data = rdata_q;
  assign unused_ok   = ^{i_read_addr[1:0], i_write_addr[1:0], i_byte_enable[3:1], i_write_data[31:8], tx_count};
endmodule
